// File: rtl/bus_rr_2m.sv
// bus_rr_2m: two-master, NS-slave system bus with a registered round-robin
// arbiter, address-window slave decode and a 1-cycle registered read select.
//
// Ports:
//   clk, reset_n            system clock (rising edge), synchronous active-low reset
//   m0_req/wr/addr/dout     master 0 request, write strobe, address, write data
//   m1_req/wr/addr/dout     master 1, same meaning
//   m0_grant, m1_grant      registered bus ownership, decoded from arbiter state
//   m_din                   read data back to both masters (from previous cycle's select)
//   s_sel                   one-hot slave select (lowest index wins on overlap)
//   s_addr, s_wr, s_din     slave-side address / write strobe / write data
//   s_dout                  packed slave read data, slave i at [i*DW +: DW]
//   bus_err                 registered decode-error flag for the previous granted cycle
module bus_rr_2m #(
  parameter int              DW     = 64,
  parameter int              AW     = 16,
  parameter int              NS     = 2,
  parameter logic [NS*AW-1:0] S_BASE = {16'h7000, 16'h0000},
  parameter logic [NS*AW-1:0] S_LAST = {16'h71FF, 16'h07FF}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             m0_req,
  input  logic             m0_wr,
  input  logic [AW-1:0]    m0_addr,
  input  logic [DW-1:0]    m0_dout,
  input  logic             m1_req,
  input  logic             m1_wr,
  input  logic [AW-1:0]    m1_addr,
  input  logic [DW-1:0]    m1_dout,
  output logic             m0_grant,
  output logic             m1_grant,
  output logic [DW-1:0]    m_din,
  output logic [NS-1:0]    s_sel,
  output logic [AW-1:0]    s_addr,
  output logic             s_wr,
  output logic [DW-1:0]    s_din,
  input  logic [NS*DW-1:0] s_dout,
  output logic             bus_err
);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t          state, state_nxt;
  logic            last_srv;   // 0: master 0 served last, 1: master 1
  logic [NS-1:0]   sel_q;
  logic            granted;
  logic            hit_any;
  logic            mux_wr;

  // Arbiter next state: owner keeps the bus while requesting, hands over
  // directly to a waiting master, ties from IDLE go to the one not served last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (m0_req && m1_req) state_nxt = last_srv ? G0 : G1;
        else if (m0_req)      state_nxt = G0;
        else if (m1_req)      state_nxt = G1;
      end
      G0: begin
        if (!m0_req) state_nxt = m1_req ? G1 : IDLE;
      end
      G1: begin
        if (!m1_req) state_nxt = m0_req ? G0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m0_grant = (state == G0);
  assign m1_grant = (state == G1);
  assign granted  = m0_grant || m1_grant;

  // Slave-side mux from the current owner; zero when idle.
  always_comb begin
    s_addr = '0;
    s_din  = '0;
    mux_wr = 1'b0;
    if (m0_grant) begin
      s_addr = m0_addr;
      s_din  = m0_dout;
      mux_wr = m0_wr;
    end else if (m1_grant) begin
      s_addr = m1_addr;
      s_din  = m1_dout;
      mux_wr = m1_wr;
    end
  end

  // Window decode: first matching slave from index 0 upward wins.
  always_comb begin
    logic [AW-1:0] base_v;
    logic [AW-1:0] last_v;
    s_sel   = '0;
    hit_any = 1'b0;
    for (int i = 0; i < NS; i++) begin
      base_v = S_BASE[i*AW +: AW];
      last_v = S_LAST[i*AW +: AW];
      if (granted && !hit_any && (s_addr >= base_v) && (s_addr <= last_v)) begin
        s_sel[i] = 1'b1;
        hit_any  = 1'b1;
      end
    end
  end

  // Writes to unmapped addresses never reach a slave.
  assign s_wr = mux_wr && hit_any;

  // Read return uses the select registered on the previous edge.
  always_comb begin
    m_din = '0;
    for (int i = 0; i < NS; i++) begin
      if (sel_q[i]) m_din = m_din | s_dout[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
    if (!reset_n) begin
      state    <= IDLE;
      last_srv <= 1'b1;
      sel_q    <= '0;
      bus_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel_q   <= s_sel;
      bus_err <= granted && !hit_any;
      if (state_nxt == G0) last_srv <= 1'b0;
      else if (state_nxt == G1) last_srv <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_rr_2m.sv
// Directed testbench for bus_rr_2m: reset, decode/read path, write gating,
// no-preemption, mid-transaction reset and round-robin tie-break.
module tb_bus_rr_2m;

  localparam int DW = 64;
  localparam int AW = 16;
  localparam int NS = 2;

  localparam logic [DW-1:0] D0 = 64'h1111_1111_1111_1111;
  localparam logic [DW-1:0] D1 = 64'h7777_7777_7777_7777;
  localparam logic [DW-1:0] DF = 64'hFFFF_FFFF_FFFF_FFFF;

  logic             clk;
  logic             reset_n;
  logic             m0_req, m0_wr, m1_req, m1_wr;
  logic [AW-1:0]    m0_addr, m1_addr;
  logic [DW-1:0]    m0_dout, m1_dout;
  logic             m0_grant, m1_grant;
  logic [DW-1:0]    m_din;
  logic [NS-1:0]    s_sel;
  logic [AW-1:0]    s_addr;
  logic             s_wr;
  logic [DW-1:0]    s_din;
  logic [NS*DW-1:0] s_dout;
  logic             bus_err;

  int checks   = 0;
  int failures = 0;

  // Decode table: address, required select, required bus_err and m_din one cycle later.
  logic [AW-1:0] dec_addr [6] = '{16'h0000, 16'h07FF, 16'h3000, 16'h7000, 16'h71FF, 16'h7FFF};
  logic [NS-1:0] dec_sel  [6] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
  logic          dec_err  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [DW-1:0] dec_din  [6] = '{D0, D0, 64'h0, D1, D1, 64'h0};

  bus_rr_2m #(.DW(DW), .AW(AW), .NS(NS)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant), .m_din(m_din),
    .s_sel(s_sel), .s_addr(s_addr), .s_wr(s_wr), .s_din(s_din),
    .s_dout(s_dout), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are changed and outputs sampled 2 time units after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
    step(); step();
    checks++;
    if (m0_grant !== 1'b0 || m1_grant !== 1'b0) begin
      failures++; $display("FAIL reset_grants got=%b%b want=00", m0_grant, m1_grant);
    end
    checks++;
    if (s_sel !== 2'b00) begin failures++; $display("FAIL reset_s_sel got=%b want=00", s_sel); end
    checks++;
    if (m_din !== 64'h0) begin failures++; $display("FAIL reset_m_din got=%h want=0", m_din); end
    checks++;
    if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_bus_err got=%b want=0", bus_err); end
    reset_n = 1'b1; m1_req = 1'b0;
    step();
    checks++;
    if (m0_grant !== 1'b1 || m1_grant !== 1'b0) begin
      failures++; $display("FAIL reset_release_grant got=%b%b want=10", m0_grant, m1_grant);
    end
  endtask

  task automatic test_decode_read();
    for (int i = 0; i < 6; i++) begin
      m0_addr = dec_addr[i];
      #1;
      checks++;
      if (s_sel !== dec_sel[i]) begin
        failures++; $display("FAIL decode_sel[%0d] addr=%h got=%b want=%b", i, dec_addr[i], s_sel, dec_sel[i]);
      end
      step();
      checks++;
      if (m_din !== dec_din[i]) begin
        failures++; $display("FAIL read_m_din[%0d] got=%h want=%h", i, m_din, dec_din[i]);
      end
      checks++;
      if (bus_err !== dec_err[i]) begin
        failures++; $display("FAIL decode_bus_err[%0d] got=%b want=%b", i, bus_err, dec_err[i]);
      end
    end
  endtask

  task automatic test_write_gating();
    m0_wr = 1'b1; m0_dout = DF; m0_addr = 16'h0666;
    #1;
    checks++;
    if (s_wr !== 1'b1 || s_din !== DF || s_sel !== 2'b01) begin
      failures++; $display("FAIL write_mapped got wr=%b din=%h sel=%b want wr=1 din=%h sel=01", s_wr, s_din, s_sel, DF);
    end
    m0_addr = 16'h3000;
    #1;
    checks++;
    if (s_wr !== 1'b0 || s_sel !== 2'b00) begin
      failures++; $display("FAIL write_unmapped got wr=%b sel=%b want wr=0 sel=00", s_wr, s_sel);
    end
    step();
    m0_wr = 1'b0; m0_addr = 16'h0000;
  endtask

  task automatic test_no_preemption();
    // Hand over from G0 to G1 directly, then keep m0 requesting.
    m0_req = 1'b0; m1_req = 1'b1;
    step();
    checks++;
    if (m1_grant !== 1'b1 || m0_grant !== 1'b0) begin
      failures++; $display("FAIL handover_g0_g1 got=%b%b want=01", m0_grant, m1_grant);
    end
    m0_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (m1_grant !== 1'b1 || m0_grant !== 1'b0) begin
        failures++; $display("FAIL no_preempt[%0d] got=%b%b want=01", c, m0_grant, m1_grant);
      end
    end
    m1_req = 1'b0;
    step();
    checks++;
    if (m0_grant !== 1'b1 || m1_grant !== 1'b0) begin
      failures++; $display("FAIL preempt_release got=%b%b want=10", m0_grant, m1_grant);
    end
  endtask

  task automatic test_mid_reset();
    m0_req = 1'b0; m1_req = 1'b1; m1_addr = 16'h7000;
    step();
    step();
    checks++;
    if (m1_grant !== 1'b1 || m_din !== D1) begin
      failures++; $display("FAIL midrst_setup got grant=%b din=%h want grant=1 din=%h", m1_grant, m_din, D1);
    end
    reset_n = 1'b0;
    step();
    checks++;
    if (m1_grant !== 1'b0 || m_din !== 64'h0) begin
      failures++; $display("FAIL midrst_drop got grant=%b din=%h want grant=0 din=0", m1_grant, m_din);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (m1_grant !== 1'b1 || m0_grant !== 1'b0) begin
      failures++; $display("FAIL midrst_regrant got=%b%b want=01", m0_grant, m1_grant);
    end
    m1_req = 1'b0; m1_addr = 16'h0000;
    step();
  endtask

  task automatic test_tie_break();
    // Fresh reset so last_srv starts at M1.
    reset_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    step();
    reset_n = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
    step();
    checks++;
    if (m0_grant !== 1'b1 || m1_grant !== 1'b0) begin
      failures++; $display("FAIL tie_first got=%b%b want=10", m0_grant, m1_grant);
    end
    m0_req = 1'b0;
    step();
    checks++;
    if (m1_grant !== 1'b1 || m0_grant !== 1'b0) begin
      failures++; $display("FAIL tie_handover got=%b%b want=01", m0_grant, m1_grant);
    end
    m1_req = 1'b0;
    step();
    checks++;
    if (m0_grant !== 1'b0 || m1_grant !== 1'b0) begin
      failures++; $display("FAIL tie_idle got=%b%b want=00", m0_grant, m1_grant);
    end
    m0_req = 1'b1; m1_req = 1'b1;
    step();
    checks++;
    if (m0_grant !== 1'b1 || m1_grant !== 1'b0) begin
      failures++; $display("FAIL tie_second got=%b%b want=10", m0_grant, m1_grant);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_dout = '0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_dout = '0;
    s_dout = {D1, D0};
    #1;
    test_reset();
    test_decode_read();
    test_write_gating();
    test_no_preemption();
    test_mid_reset();
    test_tie_break();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
